// File: rtl/led_blink_ctrl.sv
// -----------------------------------------------------------------------------
// led_blink_ctrl
//
// Avalon-MM slave that blinks two LEDs. A shared prescaler produces the tick
// time base. Each channel runs a small IDLE/RUN/DONE FSM driven by its own
// period, duty and repeat settings. The slide switches pass through a
// two-flop synchroniser. Software can read them in STATUS, and channel 0 can
// use them directly as its duty value.
//
// Optional build macro: LED_BLINK_IRQ_EN
//   defined   -> CTRL[5] (IRQEN) exists, irq = registered IRQEN & (DONE0|DONE1)
//   undefined -> CTRL[5] reads 0 and ignores writes, irq tied low
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (0..7)
//   chipselect  slave select
//   write       write strobe, writedata captured on the same edge
//   writedata   32-bit write data
//   read        read strobe, readdata valid one cycle later
//   readdata    registered read data, holds until the next read
//   sw          raw slide switches (asynchronous)
//   led         LED drive, 1 = on
//   irq         interrupt request
//
// Register map (word address)
//   0 CTRL     [0] EN0 [1] EN1 [2] ONESHOT0 [3] ONESHOT1 [4] SWDUTY [5] IRQEN
//   1 STATUS   [1:0] DONE (W1C), [3:2] led, [8+SW_W-1:8] synchronised sw
//   2 PRESCALE 3 PERIOD0 4 DUTY0 5 PERIOD1 6 DUTY1
//   7 REPEAT   [7:0] channel 0, [15:8] channel 1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module led_blink_ctrl #(
    parameter int SW_W          = 8,
    parameter int CNT_W         = 16,
    parameter int PRESCALE_W    = 16,
    parameter int PRESCALE_INIT = 49999,
    parameter int PERIOD_INIT   = 1000,
    parameter int DUTY_INIT     = 500
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    input  logic [SW_W-1:0]   sw,
    output logic [1:0]        led,
    output logic              irq
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_PERIOD0  = 3'd3;
    localparam logic [2:0] ADDR_DUTY0    = 3'd4;
    localparam logic [2:0] ADDR_PERIOD1  = 3'd5;
    localparam logic [2:0] ADDR_DUTY1    = 3'd6;

`ifdef LED_BLINK_IRQ_EN
    localparam logic [5:0] CTRL_MASK = 6'h3F;
`else
    localparam logic [5:0] CTRL_MASK = 6'h1F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chan_state_e;

    logic                  wr_en;
    logic                  rd_en;
    logic [5:0]            ctrl_q, ctrl_d;
    logic [1:0]            done_q, done_d;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick;
    logic [1:0][CNT_W-1:0] period_q;
    logic [1:0][CNT_W-1:0] duty_q;
    logic [15:0]           repeat_q;
    logic [SW_W-1:0]       sw_meta_q, sw_sync_q;
    logic [31:0]           readdata_q, rd_word;
    logic [1:0]            led_vec;
    logic [1:0]            hw_done;
    logic                  unused_wdata;

    assign wr_en        = chipselect & write;
    assign rd_en        = chipselect & read;
    assign unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Switch synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: counts 0..PRESCALE and ticks on the terminal value.
    // A PRESCALE write restarts the count so the new rate starts cleanly.
    // ------------------------------------------------------------------
    assign tick = (pcnt_q == prescale_q);

    always_comb begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
        if (tick) begin
            pcnt_d = '0;
        end
        if (wr_en && address == ADDR_PRESCALE) begin
            pcnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // CTRL / STATUS next state. A software CTRL write overrides the
    // hardware EN clear. A DONE set overrides a same-cycle W1C.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d      = ctrl_q;
        ctrl_d[1:0] = ctrl_q[1:0] & ~hw_done;
        if (wr_en && address == ADDR_CTRL) begin
            ctrl_d = writedata[5:0] & CTRL_MASK;
        end

        done_d = done_q;
        if (wr_en && address == ADDR_STATUS) begin
            done_d = done_q & ~writedata[1:0];
        end
        done_d = done_d | hw_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            done_q     <= '0;
            pcnt_q     <= '0;
            prescale_q <= PRESCALE_W'(PRESCALE_INIT);
            period_q   <= {2{CNT_W'(PERIOD_INIT)}};
            duty_q     <= {2{CNT_W'(DUTY_INIT)}};
            repeat_q   <= 16'h0101;
        end else begin
            ctrl_q <= ctrl_d;
            done_q <= done_d;
            pcnt_q <= pcnt_d;
            if (wr_en) begin
                case (address)
                    ADDR_PRESCALE: prescale_q  <= writedata[PRESCALE_W-1:0];
                    ADDR_PERIOD0:  period_q[0] <= writedata[CNT_W-1:0];
                    ADDR_DUTY0:    duty_q[0]   <= writedata[CNT_W-1:0];
                    ADDR_PERIOD1:  period_q[1] <= writedata[CNT_W-1:0];
                    ADDR_DUTY1:    duty_q[1]   <= writedata[CNT_W-1:0];
                    3'd7:          repeat_q    <= writedata[15:0];
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_CTRL:     rd_word[5:0] = ctrl_q;
            ADDR_STATUS: begin
                rd_word[1:0]       = done_q;
                rd_word[3:2]       = led_vec;
                rd_word[8 +: SW_W] = sw_sync_q;
            end
            ADDR_PRESCALE: rd_word[PRESCALE_W-1:0] = prescale_q;
            ADDR_PERIOD0:  rd_word[CNT_W-1:0]      = period_q[0];
            ADDR_DUTY0:    rd_word[CNT_W-1:0]      = duty_q[0];
            ADDR_PERIOD1:  rd_word[CNT_W-1:0]      = period_q[1];
            ADDR_DUTY1:    rd_word[CNT_W-1:0]      = duty_q[1];
            default:       rd_word[15:0]           = repeat_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rd_word;
        end
    end

    assign readdata = readdata_q;
    assign led      = led_vec;

    // ------------------------------------------------------------------
    // Blink channels
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_chan
        chan_state_e       state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [CNT_W-1:0]  duty_eff;
        logic [CNT_W:0]    cnt_inc;
        logic [7:0]        rep_q, rep_d;
        logic [7:0]        rep_cfg, rep_lim;
        logic [8:0]        rep_inc;
        logic              led_q, led_d;
        logic              en_prev_q;
        logic              en, en_rise, oneshot, wrap, done_set;

        assign en      = ctrl_q[gi];
        assign oneshot = ctrl_q[2+gi];
        assign en_rise = en & ~en_prev_q;

        // Extra bit so cnt+1 cannot overflow when PERIOD is all ones.
        assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
        assign wrap    = (cnt_inc >= {1'b0, period_q[gi]});

        // REPEAT of 0 behaves as a single period.
        assign rep_cfg = repeat_q[8*gi +: 8];
        assign rep_lim = (rep_cfg == 8'd0) ? 8'd1 : rep_cfg;
        assign rep_inc = {1'b0, rep_q} + 9'd1;

        if (gi == 0) begin : g_duty_sw
            assign duty_eff = ctrl_q[4] ? CNT_W'(sw_sync_q) : duty_q[gi];
        end else begin : g_duty_reg
            assign duty_eff = duty_q[gi];
        end

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            rep_d    = rep_q;
            done_set = 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        rep_d   = '0;
                    end else if (tick) begin
                        if (wrap) begin
                            cnt_d = '0;
                            if (oneshot) begin
                                if (rep_inc >= {1'b0, rep_lim}) begin
                                    state_d  = ST_DONE;
                                    rep_d    = '0;
                                    done_set = 1'b1;
                                end else begin
                                    rep_d = rep_inc[7:0];
                                end
                            end
                        end else begin
                            cnt_d = cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold the counters clear. An enable edge
                    // starts at cnt=0, so a coincident tick is ignored.
                    cnt_d = '0;
                    rep_d = '0;
                    if (en_rise) begin
                        state_d = ST_RUN;
                    end
                end
            endcase
            // The LED is a registered decode of the current count. It drops
            // immediately when the channel stops or finishes.
            led_d = (state_q == ST_RUN) && en && !done_set && (cnt_q < duty_eff);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                rep_q     <= '0;
                led_q     <= 1'b0;
                en_prev_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                rep_q     <= rep_d;
                led_q     <= led_d;
                en_prev_q <= en;
            end
        end

        assign led_vec[gi] = led_q;
        assign hw_done[gi] = done_set;
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef LED_BLINK_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ctrl_q[5] & (|done_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for led_blink_ctrl: register table, then directed blink sequences.
// Build with +define+LED_BLINK_IRQ_EN to exercise the interrupt variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_led_blink_ctrl;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_PRESC  = 3'd2;
    localparam logic [2:0] A_PER0   = 3'd3;
    localparam logic [2:0] A_DUTY0  = 3'd4;
    localparam logic [2:0] A_PER1   = 3'd5;
    localparam logic [2:0] A_DUTY1  = 3'd6;
    localparam logic [2:0] A_REP    = 3'd7;

`ifdef LED_BLINK_IRQ_EN
    localparam logic [31:0] IRQ_ON   = 32'd1;
    localparam logic [31:0] CTRL_B5  = 32'h20;
`else
    localparam logic [31:0] IRQ_ON   = 32'd0;
    localparam logic [31:0] CTRL_B5  = 32'h00;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [7:0]  sw;
    logic [1:0]  led;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_blink_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .sw         (sw),
        .led        (led),
        .irq        (irq)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    typedef struct {
        logic [31:0] period;
        logic [31:0] duty;
        logic        level;
    } ch1_vec_t;

    reg_vec_t regv[16];
    ch1_vec_t ch1v[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
    endtask

    task automatic wait_led(input int ch, input logic val, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (led[ch] == val) begin
                ok = 1'b1;
                break;
            end
            tick_cyc();
        end
    endtask

    task automatic run_len(input int ch, input logic val, input int limit, output int n);
        n = 0;
        while (led[ch] == val && n < limit) begin
            n++;
            tick_cyc();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ok;
        logic        lvl;
        logic        seen_hi;
        logic        prev;
        logic        found;
        int          n;
        int          bad;
        int          pulses;
        int          len;
        int          falls;

        regv[0]  = '{1'b0, A_CTRL,   32'h0,        32'h0,             "rst CTRL"};
        regv[1]  = '{1'b0, A_STATUS, 32'h0,        32'h0,             "rst STATUS"};
        regv[2]  = '{1'b0, A_PRESC,  32'h0,        32'd49999,         "rst PRESCALE"};
        regv[3]  = '{1'b0, A_PER0,   32'h0,        32'd1000,          "rst PERIOD0"};
        regv[4]  = '{1'b0, A_DUTY0,  32'h0,        32'd500,           "rst DUTY0"};
        regv[5]  = '{1'b0, A_PER1,   32'h0,        32'd1000,          "rst PERIOD1"};
        regv[6]  = '{1'b0, A_DUTY1,  32'h0,        32'd500,           "rst DUTY1"};
        regv[7]  = '{1'b0, A_REP,    32'h0,        32'h0101,          "rst REPEAT"};
        regv[8]  = '{1'b1, A_PRESC,  32'hFFFF1234, 32'h1234,          "wr PRESCALE"};
        regv[9]  = '{1'b1, A_PER1,   32'h0001ABCD, 32'hABCD,          "wr PERIOD1"};
        regv[10] = '{1'b1, A_DUTY0,  32'hFFFFFFFF, 32'hFFFF,          "wr DUTY0"};
        regv[11] = '{1'b1, A_REP,    32'hDEADBEEF, 32'hBEEF,          "wr REPEAT"};
        regv[12] = '{1'b1, A_CTRL,   32'hFFFFFFC0, 32'h0,             "wr CTRL high bits"};
        regv[13] = '{1'b1, A_CTRL,   32'h0000003C, 32'h1C | CTRL_B5,  "wr CTRL cfg bits"};
        regv[14] = '{1'b1, A_CTRL,   32'h0,        32'h0,             "wr CTRL zero"};
        regv[15] = '{1'b1, A_STATUS, 32'hFFFFFFFF, 32'h0,             "wr STATUS ro"};

        ch1v[0] = '{32'd4, 32'd0, 1'b0};
        ch1v[1] = '{32'd4, 32'd4, 1'b1};
        ch1v[2] = '{32'd4, 32'd5, 1'b1};
        ch1v[3] = '{32'd0, 32'd4, 1'b1};
        ch1v[4] = '{32'd0, 32'd1, 1'b1};
        ch1v[5] = '{32'd1, 32'd1, 1'b1};
        ch1v[6] = '{32'd1, 32'd0, 1'b0};

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        read       = 1'b0;
        sw         = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset led", 32'(led), 32'h0);
        check("reset readdata", readdata, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // Reset asserted mid-run drops the LEDs asynchronously.
        bus_write(A_PRESC, 32'd0);
        bus_write(A_PER0, 32'd4);
        bus_write(A_DUTY0, 32'd2);
        bus_write(A_CTRL, 32'd1);
        wait_led(0, 1'b1, 50, ok);
        check("mid-run led0 rises", 32'(ok), 32'd1);
        bus_read(A_PER0, rd);
        check("mid-run PERIOD0", rd, 32'd4);
        wait_led(0, 1'b1, 50, ok);
        check("mid-run led0 high again", 32'(ok), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async reset led", 32'(led), 32'h0);
        check("async reset readdata", readdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick_cyc();

        // Register table.
        for (int i = 0; i < 16; i++) begin
            if (regv[i].wr) begin
                bus_write(regv[i].addr, regv[i].wdata);
            end
            bus_read(regv[i].addr, rd);
            check(regv[i].name, rd, regv[i].exp);
        end

        // Blink: PRESCALE=1, PERIOD0=4, DUTY0=1 -> 2 high / 6 low.
        bus_write(A_PRESC, 32'd1);
        bus_write(A_PER0, 32'd4);
        bus_write(A_DUTY0, 32'd1);
        bus_write(A_CTRL, 32'd1);
        wait_led(0, 1'b0, 100, ok);
        wait_led(0, 1'b1, 100, ok);
        check("blink start", 32'(ok), 32'd1);
        for (int k = 0; k < 2; k++) begin
            run_len(0, 1'b1, 100, n);
            check($sformatf("blink high run %0d", k), 32'(n), 32'd2);
            run_len(0, 1'b0, 100, n);
            check($sformatf("blink low run %0d", k), 32'(n), 32'd6);
        end
        seen_hi = 1'b0;
        for (int k = 0; k < 8; k++) begin
            lvl = led[0];
            seen_hi |= lvl;
            bus_read(A_STATUS, rd);
            check($sformatf("STATUS led0 read %0d", k), 32'(rd[2]), 32'(lvl));
        end
        check("STATUS led0 seen high", 32'(seen_hi), 32'd1);

        // Channel 1 boundaries at PRESCALE=0.
        bus_write(A_CTRL, 32'd0);
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CTRL, 32'd2);
        for (int i = 0; i < 7; i++) begin
            bus_write(A_PER1, ch1v[i].period);
            bus_write(A_DUTY1, ch1v[i].duty);
            repeat (4) tick_cyc();
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                if (led[1] !== ch1v[i].level) bad++;
                tick_cyc();
            end
            check($sformatf("ch1 p=%0d d=%0d off-level cycles", ch1v[i].period, ch1v[i].duty),
                  32'(bad), 32'd0);
        end
        bus_write(A_CTRL, 32'd0);

        // One-shot: PERIOD0=3, DUTY0=2, REPEAT0=2 -> two 2-cycle pulses.
        bus_write(A_PER0, 32'd3);
        bus_write(A_DUTY0, 32'd2);
        bus_write(A_REP, 32'd2);
        bus_write(A_CTRL, 32'h5);
        pulses = 0;
        len    = 0;
        prev   = led[0];
        for (int c = 0; c < 40; c++) begin
            tick_cyc();
            if (led[0] && !prev) begin
                pulses++;
                len = 1;
            end else if (led[0]) begin
                len++;
            end else if (prev) begin
                check($sformatf("oneshot pulse %0d length", pulses), 32'(len), 32'd2);
            end
            prev = led[0];
        end
        check("oneshot pulse count", 32'(pulses), 32'd2);
        bus_read(A_CTRL, rd);
        check("oneshot EN0 cleared", rd, 32'h4);
        bus_read(A_STATUS, rd);
        check("oneshot DONE0 set, led off", rd & 32'hF, 32'h1);
        check("irq idle without IRQEN", 32'(irq), 32'h0);
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, rd);
        check("DONE0 cleared by W1C", rd & 32'h3, 32'h0);

        // Switch synchroniser latency.
        sw = 8'h40;
        bus_read(A_STATUS, rd);
        check("sw not yet synchronised", 32'(rd[15:8]), 32'h00);
        bus_read(A_STATUS, rd);
        bus_read(A_STATUS, rd);
        check("sw synchronised", 32'(rd[15:8]), 32'h40);

        // Switch-driven duty on channel 0.
        bus_write(A_CTRL, 32'd0);
        bus_write(A_PER0, 32'd256);
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CTRL, 32'h11);
        wait_led(0, 1'b0, 600, ok);
        wait_led(0, 1'b1, 600, ok);
        check("swduty start", 32'(ok), 32'd1);
        run_len(0, 1'b1, 600, n);
        check("swduty 0x40 high run", 32'(n), 32'd64);
        run_len(0, 1'b0, 600, n);
        check("swduty 0x40 low run", 32'(n), 32'd192);
        sw = 8'hFF;
        repeat (258) tick_cyc();
        wait_led(0, 1'b0, 600, ok);
        wait_led(0, 1'b1, 600, ok);
        check("swduty 0xFF start", 32'(ok), 32'd1);
        run_len(0, 1'b1, 600, n);
        check("swduty 0xFF high run", 32'(n), 32'd255);
        run_len(0, 1'b0, 600, n);
        check("swduty 0xFF low run", 32'(n), 32'd1);
        bus_read(A_STATUS, rd);
        check("STATUS sw 0xFF", 32'(rd[15:8]), 32'hFF);
        bus_write(A_CTRL, 32'd0);

        // Interrupt on one-shot completion (always low without the macro).
        bus_write(A_PER0, 32'd3);
        bus_write(A_DUTY0, 32'd2);
        bus_write(A_REP, 32'd2);
        bus_write(A_CTRL, 32'h25);
        falls = 0;
        found = 1'b0;
        prev  = led[0];
        for (int c = 0; c < 40 && !found; c++) begin
            tick_cyc();
            if (prev && !led[0]) begin
                falls++;
                if (falls == 2) found = 1'b1;
            end
            prev = led[0];
        end
        check("irq run completed", 32'(found), 32'd1);
        check("irq low on DONE edge", 32'(irq), 32'h0);
        tick_cyc();
        check("irq one cycle after DONE", 32'(irq), IRQ_ON);
        bus_read(A_CTRL, rd);
        check("irq CTRL after done", rd, 32'h4 | CTRL_B5);
        bus_read(A_STATUS, rd);
        check("irq DONE0 set", rd & 32'h3, 32'h1);
        bus_write(A_STATUS, 32'h1);
        check("irq holds on W1C edge", 32'(irq), IRQ_ON);
        tick_cyc();
        check("irq drops after W1C", 32'(irq), 32'h0);

        // DONE0 set and W1C on the same edge: set wins.
        bus_write(A_CTRL, 32'h25);
        repeat (6) tick_cyc();
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, rd);
        check("DONE0 set beats W1C", rd & 32'h3, 32'h1);
        check("irq after set-vs-clear", 32'(irq), IRQ_ON);
        tick_cyc();
        check("irq stays after set-vs-clear", 32'(irq), IRQ_ON);
        bus_write(A_CTRL, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Avalon-MM slave peripheral for the Nios system. It sequences blinking on two LED outputs from programmable period, duty and repeat registers.
- A shared prescaler generates the time base for both channels.
- It synchronises the slide-switch bus. Software can read the switches, and channel 0 can take its duty directly from them.
- It sits between the Nios interconnect and the board LEDR/SW pins, and is exported through the system's external connections.

Parameters:
- SW_W, 8, switch bus width (duty source width when SWDUTY=1).
- CNT_W, 16, width of the period/duty counters and registers.
- PRESCALE_W, 16, width of the prescaler.
- PRESCALE_INIT, 49999, prescaler reset value (1 kHz tick at 50 MHz).
- PERIOD_INIT, 1000, reset value of PERIOD0/PERIOD1 in ticks.
- DUTY_INIT, 500, reset value of DUTY0/DUTY1 in ticks.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 3, word address.
- chipselect, input, 1, slave select.
- write, input, 1, write strobe.
- writedata, input, 32, write data.
- read, input, 1, read strobe.
- readdata, output, 32, read data, registered.
- sw, input, SW_W, raw slide switches (asynchronous).
- led, output, 2, LED drive, 1 = on.
- irq, output, 1, interrupt (see Optional Feature).

Behaviour:
- Reset: one clock, clk; reset_n is asynchronous active-low. While reset_n=0, all registers take reset values immediately: led=0, readdata=0, irq=0, CTRL=0, STATUS DONE=0, PRESCALE=PRESCALE_INIT, PERIODx=PERIOD_INIT, DUTYx=DUTY_INIT, REPEAT=0x0101. Counters and synchronisers clear to 0.
- Register map (word address, unmapped bits read 0):
  - 0 CTRL rw: [0] EN0, [1] EN1, [2] ONESHOT0, [3] ONESHOT1, [4] SWDUTY, [5] IRQEN.
  - 1 STATUS: [0] DONE0, [1] DONE1 (write 1 to clear); [3:2] led (ro); [8+SW_W-1:8] synchronised sw (ro).
  - 2 PRESCALE: [PRESCALE_W-1:0].
  - 3 PERIOD0, 4 DUTY0, 5 PERIOD1, 6 DUTY1: [CNT_W-1:0].
  - 7 REPEAT: [7:0] channel 0, [15:8] channel 1.
- Bus timing: a write takes effect on the clk edge where chipselect&write=1. readdata is valid exactly 1 cycle after chipselect&read (read latency 1) and holds until the next read. There are no wait states.
- Switch synchroniser: sw passes through a 2-flop synchroniser. A sw change appears in STATUS and the duty path 2 cycles later.
- Prescaler:
  - pcnt counts 0..PRESCALE. tick=1 for one cycle when pcnt==PRESCALE, then pcnt wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
  - A write to PRESCALE clears pcnt.
- Channel FSM per channel x, states IDLE, RUN, DONE:
  - IDLE: cnt=0, rep=0, led=0. An ENx 0->1 transition moves to RUN.
  - RUN: led = (cnt < effective duty). Effective duty is DUTYx, or zero-extended sync sw when x=0 and SWDUTY=1.
    - On tick: if cnt+1 >= PERIODx then cnt=0 (period wrap), else cnt=cnt+1.
    - PERIOD 0 or 1: cnt stays 0.
    - Duty 0: led stays 0. Duty >= PERIOD: led stays 1.
  - One-shot: on a period wrap with ONESHOTx=1, rep increments. When rep+1 >= max(REPEATx,1), the FSM goes to DONE, clears ENx (hardware), sets DONEx and forces led=0.
  - DONE: behaves as IDLE. The next ENx 0->1 transition restarts the channel.
  - ENx cleared by software in any state: go to IDLE next cycle, led=0.
- led is registered and changes 1 cycle after the tick edge that causes it.
- Writes to PERIOD/DUTY while in RUN take effect immediately. If cnt >= new PERIOD-1, the channel wraps at the next tick.
- Simultaneous events:
  - Software CTRL write in the same cycle as a hardware ENx clear: the software value wins.
  - DONEx set and write-1-to-clear in the same cycle: set wins.
  - Tick in the same cycle as an ENx rising edge: cnt starts at 0 and the tick is ignored.
- Reset asserted mid-operation: immediate return to reset values. There is no pending state.

Optional Feature:
- Macro: LED_BLINK_IRQ_EN.
- Defined: irq is registered and equals IRQEN & (DONE0|DONE1). It asserts 1 cycle after DONEx sets and deasserts 1 cycle after the write-1-to-clear.
- Undefined: irq is tied 0, CTRL[5] is not implemented and reads 0, and writes to it are ignored.

Test Plan:
- Reset with reset_n=0 mid-run (EN0=1) -> led=00 asynchronously. After release, reads return CTRL=0, PRESCALE=49999, PERIOD0=1000, DUTY0=500, REPEAT=0x0101.
- PRESCALE=1, PERIOD0=4, DUTY0=1, EN0=1 -> led[0] high for 2 cycles, low for 6, repeating. Read STATUS[2] tracks it.
- Channel 1 boundaries (PRESCALE=0): PERIOD1=4, DUTY1=0 -> led[1] stays 0. DUTY1=4 -> led[1] stays 1. PERIOD1=0 -> led[1]=1 constant with DUTY1>=1.
- PRESCALE=0, PERIOD0=3, DUTY0=2, ONESHOT0=1, REPEAT[7:0]=2, EN0=1 -> exactly 2 pulses of 2 cycles. Then EN0 reads 0, DONE0=1, led[0]=0. Write STATUS=1 -> DONE0 reads 0.
- SWDUTY=1, PERIOD0=256, sw=0x40, PRESCALE=0 -> led[0] high 64 of every 256 cycles. After sw changes to 0xFF, this becomes 255 of every 256 within one period plus 2 cycles.
- With LED_BLINK_IRQ_EN defined: IRQEN=1 and the one-shot completes -> irq=1 one cycle after DONE0 sets. Write-1-to-clear DONE0 in the same cycle as a new DONE0 set -> DONE0 stays 1 and irq stays 1. With the macro undefined, irq=0 throughout.
